// File: rtl/fetch_prefetch_queue.sv
// Fetch stage: owns the PC, issues one instruction read per cycle and buffers
// {pc, instr} pairs in a DEPTH-entry FIFO that decode drains via valid/ready.
module fetch_prefetch_queue #(
    parameter int unsigned      XLEN     = 32,
    parameter int unsigned      ILEN     = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int unsigned      PC_STEP  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic                         imem_req,
    output logic [XLEN-1:0]              imem_addr,
    input  logic [ILEN-1:0]              imem_rdata,
    input  logic                         redirect_valid,
    input  logic [XLEN-1:0]              redirect_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [XLEN-1:0]              out_pc,
    output logic [ILEN-1:0]              out_instr,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] pc_q;
    logic            inflight;
    logic [CW-1:0]   count;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [ILEN-1:0] instr_mem [DEPTH];

    logic [CW:0]     credit;
    logic            push;
    logic            pop;

    // Credit counts the outstanding read, so a response always finds a free slot.
    assign credit    = {1'b0, count} + (CW+1)'(inflight);
    assign imem_req  = !reset && !redirect_valid && (credit < (CW+1)'(DEPTH));
    assign imem_addr = reset ? RESET_PC : fetch_pc;

    assign out_valid = !reset && (count != '0);
    assign out_pc    = out_valid ? pc_mem[rd_ptr]    : '0;
    assign out_instr = out_valid ? instr_mem[rd_ptr] : '0;
    assign occupancy = reset ? '0 : count;

    // A redirect squashes both the arriving response and any pop in that cycle.
    assign push = inflight && !reset && !redirect_valid;
    assign pop  = out_valid && out_ready && !redirect_valid;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would chain updates within one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            pc_q     <= '0;
            inflight <= 1'b0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & ~XLEN'(3);
            inflight <= 1'b0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                fetch_pc <= fetch_pc + XLEN'(PC_STEP);
                pc_q     <= fetch_pc;
            end
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; count/pointers alone decide which
    // entries are live, so clearing the data would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= pc_q;
            instr_mem[wr_ptr] <= imem_rdata;
        end
    end

endmodule
